// File: rtl/mips_main_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath.
// Steps each instruction through FETCH/DECODE and then the execute, memory and
// writeback states for its opcode. Drives aluOp for alu_control, every datapath
// mux select and write strobe, counts retired instructions and flags opcodes it
// does not recognise. Control outputs are registered and loaded from the decode
// of the next state, so they always match the state register.
module mips_main_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    output logic [1:0]       aluOp,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic [1:0]       pcSource,
    output logic             iorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             regDst,
    output logic             regWrite,
    output logic             memToReg,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // Encodings 12..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WRITE = 4'd4,
        S_MEM_WB    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    typedef struct packed {
        logic [1:0] aluOp;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       pcWrite;
        logic       pcWriteCond;
        logic [1:0] pcSource;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       regWrite;
        logic       memToReg;
        logic       instr_done;
    } ctrl_t;

    // Per-state control word; anything not set is 0.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memRead = 1'b1; c.irWrite = 1'b1; c.pcWrite = 1'b1;
                c.aluSrcB = 2'b01;
            end
            S_DECODE:    c.aluSrcB = 2'b11;
            S_MEM_ADDR,
            S_ADDI_EXEC: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            S_MEM_READ:  begin c.memRead = 1'b1; c.iorD = 1'b1; end
            S_MEM_WRITE: begin c.memWrite = 1'b1; c.iorD = 1'b1; c.instr_done = 1'b1; end
            S_MEM_WB:    begin c.regWrite = 1'b1; c.memToReg = 1'b1; c.instr_done = 1'b1; end
            S_R_EXEC:    begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
            S_R_WB:      begin c.regWrite = 1'b1; c.regDst = 1'b1; c.instr_done = 1'b1; end
            S_ADDI_WB:   begin c.regWrite = 1'b1; c.instr_done = 1'b1; end
            S_BRANCH: begin
                c.aluSrcA = 1'b1; c.aluOp = 2'b01; c.pcWriteCond = 1'b1;
                c.pcSource = 2'b01; c.instr_done = 1'b1;
            end
            S_JUMP:      begin c.pcWrite = 1'b1; c.pcSource = 2'b10; c.instr_done = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    state_t          state_q, state_d;
    ctrl_t           ctrl_q, ctrl_out;
    logic [CNT_W-1:0] cnt_q;
    logic            st_legal, st_term, op_known;

    // Opcode recognition, used for dispatch and the illegal flag.
    always_comb begin
        op_known = 1'b0;
        case (opcode)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_known = 1'b1;
            default: op_known = 1'b0;
        endcase
    end

    // State classification: legal encoding and terminal (retiring) states.
    always_comb begin
        st_legal = 1'b1;
        st_term  = 1'b0;
        case (state_q)
            S_MEM_WRITE, S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: st_term = 1'b1;
            S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_R_EXEC, S_ADDI_EXEC: st_term = 1'b0;
            default: st_legal = 1'b0;
        endcase
    end

    // Next-state logic; every unlisted or unused state returns to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    // State, registered control word and retire counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode(S_FETCH);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d);
            if (st_term && st_legal)
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Outputs are held at 0 during reset and while the state is an unused encoding.
    assign ctrl_out    = (rst_n && st_legal) ? ctrl_q : '0;
    assign aluOp       = ctrl_out.aluOp;
    assign aluSrcA     = ctrl_out.aluSrcA;
    assign aluSrcB     = ctrl_out.aluSrcB;
    assign pcWrite     = ctrl_out.pcWrite;
    assign pcWriteCond = ctrl_out.pcWriteCond;
    assign pcSource    = ctrl_out.pcSource;
    assign iorD        = ctrl_out.iorD;
    assign memRead     = ctrl_out.memRead;
    assign memWrite    = ctrl_out.memWrite;
    assign irWrite     = ctrl_out.irWrite;
    assign regDst      = ctrl_out.regDst;
    assign regWrite    = ctrl_out.regWrite;
    assign memToReg    = ctrl_out.memToReg;
    assign instr_done  = ctrl_out.instr_done;
    assign illegal_op  = rst_n && (state_q == S_DECODE) && !op_known;
    assign instr_count = rst_n ? cnt_q : '0;

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Directed bench for mips_main_control_fsm: a vector table of per-cycle
// inputs and expected outputs, then a hand-written counter-wrap sequence.
module tb_mips_main_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [17:0] o32, o4;
    logic [31:0] cnt32;
    logic [3:0]  cnt4;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    // Output bit order: aluOp[17:16] aluSrcA[15] aluSrcB[14:13] pcWrite[12]
    // pcWriteCond[11] pcSource[10:9] iorD[8] memRead[7] memWrite[6] irWrite[5]
    // regDst[4] regWrite[3] memToReg[2] instr_done[1] illegal_op[0]
    mips_main_control_fsm #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .aluOp(o32[17:16]), .aluSrcA(o32[15]), .aluSrcB(o32[14:13]),
        .pcWrite(o32[12]), .pcWriteCond(o32[11]), .pcSource(o32[10:9]),
        .iorD(o32[8]), .memRead(o32[7]), .memWrite(o32[6]), .irWrite(o32[5]),
        .regDst(o32[4]), .regWrite(o32[3]), .memToReg(o32[2]),
        .instr_done(o32[1]), .illegal_op(o32[0]), .instr_count(cnt32)
    );

    mips_main_control_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .aluOp(o4[17:16]), .aluSrcA(o4[15]), .aluSrcB(o4[14:13]),
        .pcWrite(o4[12]), .pcWriteCond(o4[11]), .pcSource(o4[10:9]),
        .iorD(o4[8]), .memRead(o4[7]), .memWrite(o4[6]), .irWrite(o4[5]),
        .regDst(o4[4]), .regWrite(o4[3]), .memToReg(o4[2]),
        .instr_done(o4[1]), .illegal_op(o4[0]), .instr_count(cnt4)
    );

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111, JAL = 6'b000011;

    //                            aO A  sB W C pS I R W ir d rw m dn il
    localparam logic [17:0] ZERO = 18'b00_0_00_0_0_00_0_0_0_0_0_0_0_0_0;
    localparam logic [17:0] FE   = 18'b00_0_01_1_0_00_0_1_0_1_0_0_0_0_0;
    localparam logic [17:0] DE   = 18'b00_0_11_0_0_00_0_0_0_0_0_0_0_0_0;
    localparam logic [17:0] DEI  = 18'b00_0_11_0_0_00_0_0_0_0_0_0_0_0_1;
    localparam logic [17:0] MA   = 18'b00_1_10_0_0_00_0_0_0_0_0_0_0_0_0;
    localparam logic [17:0] MR   = 18'b00_0_00_0_0_00_1_1_0_0_0_0_0_0_0;
    localparam logic [17:0] MW   = 18'b00_0_00_0_0_00_1_0_1_0_0_0_0_1_0;
    localparam logic [17:0] MWB  = 18'b00_0_00_0_0_00_0_0_0_0_0_1_1_1_0;
    localparam logic [17:0] RX   = 18'b10_1_00_0_0_00_0_0_0_0_0_0_0_0_0;
    localparam logic [17:0] RWB  = 18'b00_0_00_0_0_00_0_0_0_0_1_1_0_1_0;
    localparam logic [17:0] AWB  = 18'b00_0_00_0_0_00_0_0_0_0_0_1_0_1_0;
    localparam logic [17:0] BR   = 18'b01_1_00_0_1_01_0_0_0_0_0_0_0_1_0;
    localparam logic [17:0] JP   = 18'b00_0_00_1_0_10_0_0_0_0_0_0_0_1_0;

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic [17:0] exp;
        int          cnt;
    } vec_t;

    localparam int NV = 34;
    vec_t tbl [NV];

    // One cycle: drive on the falling edge, check just after it.
    task automatic step(input logic r, input logic [5:0] op, input logic [17:0] exp,
                        input int cnt, input string nm);
        @(negedge clk);
        rst_n  = r;
        opcode = op;
        #1;
        nvec++;
        if (o32 !== exp) begin
            nerr++;
            $display("FAIL %s ctrl got %b want %b", nm, o32, exp);
        end
        nvec++;
        if (cnt32 !== cnt) begin
            nerr++;
            $display("FAIL %s count got %0d want %0d", nm, cnt32, cnt);
        end
        nvec++;
        if (cnt4 !== cnt[3:0]) begin
            nerr++;
            $display("FAIL %s count4 got %0d want %0d", nm, cnt4, cnt[3:0]);
        end
        nvec++;
        if ((o32[12] && o32[11]) || (o32[7] && o32[6])) begin
            nerr++;
            $display("FAIL %s exclusive strobes got %b want no pcWrite+pcWriteCond or memRead+memWrite", nm, o32);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, LW,   ZERO, 0};
        tbl[1]  = '{1'b0, LW,   ZERO, 0};
        tbl[2]  = '{1'b1, LW,   FE,   0};
        tbl[3]  = '{1'b1, LW,   DE,   0};
        tbl[4]  = '{1'b1, LW,   MA,   0};
        tbl[5]  = '{1'b1, LW,   MR,   0};
        tbl[6]  = '{1'b1, LW,   MWB,  0};
        tbl[7]  = '{1'b1, R,    FE,   1};
        tbl[8]  = '{1'b1, R,    DE,   1};
        tbl[9]  = '{1'b1, R,    RX,   1};
        tbl[10] = '{1'b1, R,    RWB,  1};
        tbl[11] = '{1'b1, SW,   FE,   2};
        tbl[12] = '{1'b1, SW,   DE,   2};
        tbl[13] = '{1'b1, SW,   MA,   2};
        tbl[14] = '{1'b1, SW,   MW,   2};
        tbl[15] = '{1'b1, BEQ,  FE,   3};
        tbl[16] = '{1'b1, BEQ,  DE,   3};
        tbl[17] = '{1'b1, BEQ,  BR,   3};
        tbl[18] = '{1'b1, J,    FE,   4};
        tbl[19] = '{1'b1, J,    DE,   4};
        tbl[20] = '{1'b1, J,    JP,   4};
        tbl[21] = '{1'b1, ADDI, FE,   5};
        tbl[22] = '{1'b1, ADDI, DE,   5};
        tbl[23] = '{1'b1, ADDI, MA,   5};
        tbl[24] = '{1'b1, ADDI, AWB,  5};
        tbl[25] = '{1'b1, BAD,  FE,   6};
        tbl[26] = '{1'b1, BAD,  DEI,  6};
        tbl[27] = '{1'b1, LW,   FE,   6};
        tbl[28] = '{1'b1, LW,   DE,   6};
        tbl[29] = '{1'b1, LW,   MA,   6};
        tbl[30] = '{1'b0, LW,   ZERO, 0};  // reset lands during MEM_READ
        tbl[31] = '{1'b1, JAL,  FE,   0};
        tbl[32] = '{1'b1, JAL,  DEI,  0};
        tbl[33] = '{1'b1, BEQ,  FE,   0};

        for (int i = 0; i < NV; i++)
            step(tbl[i].r, tbl[i].op, tbl[i].exp, tbl[i].cnt, $sformatf("vec%0d", i));

        // 16 back-to-back beq retires: the 4-bit counter wraps to 0.
        for (int k = 0; k < 16; k++) begin
            step(1'b1, BEQ, DE, k,     $sformatf("wrap_de%0d", k));
            step(1'b1, BEQ, BR, k,     $sformatf("wrap_br%0d", k));
            step(1'b1, BEQ, FE, k + 1, $sformatf("wrap_fe%0d", k));
        end
        nvec++;
        if (cnt4 !== 4'd0 || cnt32 !== 32'd16) begin
            nerr++;
            $display("FAIL wrap got cnt4=%0d cnt32=%0d want cnt4=0 cnt32=16", cnt4, cnt32);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
